// File: rtl/ex_muldiv_pkg.sv
// ----------------------------------------------------------------------------
// ex_muldiv_pkg
// Shared definitions for the EX-stage multiply/divide unit: operation
// encodings, the sequencer state enum and the iteration count.
// ----------------------------------------------------------------------------
package ex_muldiv_pkg;

    // One result bit is produced per CALC cycle, so a full 32-bit operand
    // needs this many iterations.
    localparam int ITER = 32;

    // Counter value seen during the final CALC iteration.
    localparam logic [4:0] LAST_ITER = 5'(ITER - 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv_abs_neg32.sv
// ----------------------------------------------------------------------------
// abs_neg32
// Combinational conditional two's complement. Used both to take magnitudes
// of signed operands and to restore result signs after the unsigned core.
//   a_i   : 32-bit value
//   neg_i : 1 = output -a_i, 0 = pass a_i through
//   y_o   : result
// ----------------------------------------------------------------------------
module abs_neg32 (
    input  logic [31:0] a_i,
    input  logic        neg_i,
    output logic [31:0] y_o
);

    assign y_o = neg_i ? (~a_i + 32'd1) : a_i;

endmodule

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
// Iterative multiply/divide unit for the EX stage. Signed operations are
// reduced to unsigned magnitudes on start, iterated one bit per cycle
// (shift-add multiply, restoring divide) and sign-corrected in FIX.
//   clk_i, rst_i (async, active-low)
//   start_i, op_i, src1_i, src2_i : request and operands from ID/EX
//   flush_i      : synchronous abort
//   busy_o       : high while not IDLE (pipeline stall)
//   done_o       : one-cycle completion pulse, hi_o/lo_o valid
//   hi_o, lo_o   : HI/LO registers
//   div_zero_o   : qualifies done_o, divide by zero occurred
// ----------------------------------------------------------------------------
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    // acc: product high word / partial remainder
    // quo: multiplier shifting out, product low word / dividend -> quotient
    // opb: multiplicand / divisor magnitude
    logic [31:0] acc_q, acc_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        div_zero_q, div_zero_d;

    op_e         op_in;
    logic        in_signed;
    logic [31:0] abs1, abs2;

    assign op_in     = op_e'(op_i);
    assign in_signed = op_is_signed(op_in);

    abs_neg32 u_abs_src1 (
        .a_i   (src1_i),
        .neg_i (in_signed & src1_i[31]),
        .y_o   (abs1)
    );

    abs_neg32 u_abs_src2 (
        .a_i   (src2_i),
        .neg_i (in_signed & src2_i[31]),
        .y_o   (abs2)
    );

    // One iteration of each algorithm. The multiply sum keeps its carry so
    // the shifted product stays exact; the divide difference carries an
    // extra bit whose sign says whether the trial subtraction succeeded.
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;

    assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : 33'd0);
    assign div_shift = {acc_q, quo_q[31]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb_q};

    // Sign correction. Signs were captured already masked by signedness,
    // so unsigned operations never negate.
    logic        is_div;
    logic        prod_neg, quo_neg, rem_neg;
    logic        lo_zero;
    logic [31:0] fix_lo, fix_hi_raw, fix_hi;

    assign is_div   = op_is_div(op_q);
    assign prod_neg = ~is_div & (sign1_q ^ sign2_q);
    assign quo_neg  = is_div & (sign1_q ^ sign2_q);
    assign rem_neg  = is_div & sign1_q;
    assign lo_zero  = (quo_q == 32'd0);

    abs_neg32 u_fix_lo (
        .a_i   (quo_q),
        .neg_i (prod_neg | quo_neg),
        .y_o   (fix_lo)
    );

    // A 64-bit negate only carries into the high word when the low word is
    // zero; otherwise the high word is just inverted.
    abs_neg32 u_fix_hi (
        .a_i   (acc_q),
        .neg_i (rem_neg | (prod_neg & lo_zero)),
        .y_o   (fix_hi_raw)
    );

    assign fix_hi = (prod_neg & ~lo_zero) ? ~acc_q : fix_hi_raw;

    // Next-state and datapath logic for the sequencer.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        sign1_d    = sign1_q;
        sign2_d    = sign2_q;
        acc_d      = acc_q;
        quo_d      = quo_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // flush wins over a simultaneous start
                if (start_i && !flush_i) begin
                    op_d    = op_in;
                    sign1_d = in_signed & src1_i[31];
                    sign2_d = in_signed & src2_i[31];
                    cnt_d   = 5'd0;
                    acc_d   = 32'd0;
                    if (op_is_div(op_in)) begin
                        quo_d = abs1;
                        opb_d = abs2;
                    end else begin
                        quo_d = abs2;
                        opb_d = abs1;
                    end
                    if (op_is_div(op_in) && (src2_i == 32'd0)) begin
                        state_d    = ST_DONE;
                        hi_d       = src1_i;
                        lo_d       = 32'hFFFF_FFFF;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div) begin
                        if (!div_diff[33]) begin
                            acc_d = div_diff[31:0];
                            quo_d = {quo_q[30:0], 1'b1};
                        end else begin
                            acc_d = div_shift[31:0];
                            quo_d = {quo_q[30:0], 1'b0};
                        end
                    end else begin
                        acc_d = mul_sum[32:1];
                        quo_d = {mul_sum[0], quo_q[31:1]};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    hi_d    = fix_hi;
                    lo_d    = fix_lo;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // All state, including the registered status outputs, lives here.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= 5'd0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            acc_q      <= 32'd0;
            quo_q      <= 32'd0;
            opb_q      <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            sign1_q    <= sign1_d;
            sign2_q    <= sign2_d;
            acc_q      <= acc_d;
            quo_q      <= quo_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = div_zero_q;

endmodule
